// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the IF/MEM SRAM-port arbiter: owner IDs, grant FSM states, size codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_req_arbiter_pkg;

    // Owner recorded for every accepted transaction
    typedef enum logic {
        ARB_ID_INST = 1'b0,
        ARB_ID_DATA = 1'b1
    } arb_id_t;

    // Grant FSM: free choice, or held on one requester until its request is accepted
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_D = 2'd1,
        ST_LOCK_I = 2'd2
    } arb_state_t;

    // SRAM-like byte count codes
    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;

    // Address-phase command fields that travel through the grant mux
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response channel shared by the IF, MEM and downstream sides.
// Latency: n/a (wires only).
// Backpressure: addr_ok accepts the address phase; data_ok returns one response beat.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // Side that issues requests
    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    // Side that accepts requests and returns responses
    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter_arb_id_fifo.sv
// In-order FIFO of owner IDs for accepted-but-unanswered transactions.
// Latency: head is registered; push/pop take effect at the next clock edge.
// Backpressure: full/empty exposed; push while full and pop while empty are ignored.
module arb_id_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  arb_id_t        push_id,
    input  logic           pop,
    output arb_id_t        head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    arb_id_t          id_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which also covers the single-entry case
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = id_q[rd_ptr];

    // Storage write; entries need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            id_q[wr_ptr] <= push_id;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between IF and MEM; data has fixed priority, grant held until accepted.
// Latency: zero-cycle passthrough of request, addr_ok, data_ok and rdata.
// Backpressure: mem_req withheld while OUTST transactions are outstanding (registered count only).
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTST   = 2,
    parameter int OUTST_W = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_req_arbiter_if.slave    inst,
    sram_req_arbiter_if.slave    data,
    sram_req_arbiter_if.master   mem,
    output logic [OUTST_W:0]     outst_cnt,
    output logic                 resp_err
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       grant_inst;
    logic       grant_data;
    logic       mem_req_int;
    logic       accept;
    logic       resp_hit;
    sram_cmd_t  inst_cmd;
    sram_cmd_t  data_cmd;
    sram_cmd_t  sel_cmd;
    arb_id_t    fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    assign inst_cmd = {inst.wr, inst.size, inst.addr, inst.wstrb, inst.wdata};
    assign data_cmd = {data.wr, data.size, data.addr, data.wstrb, data.wdata};

    // Grant state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant choice, downstream request and next state; a locked owner dropping req releases the lock
    always_comb begin
        state_nxt   = state;
        grant_inst  = 1'b0;
        grant_data  = 1'b0;
        mem_req_int = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data.req) begin
                    grant_data = 1'b1;
                end else if (inst.req) begin
                    grant_inst = 1'b1;
                end
                mem_req_int = ((grant_data & data.req) | (grant_inst & inst.req)) & ~fifo_full;
                if (mem_req_int && !mem.addr_ok) begin
                    state_nxt = grant_data ? ST_LOCK_D : ST_LOCK_I;
                end
            end
            ST_LOCK_D: begin
                grant_data  = 1'b1;
                mem_req_int = data.req & ~fifo_full;
                if (!data.req || mem.addr_ok) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOCK_I: begin
                grant_inst  = 1'b1;
                mem_req_int = inst.req & ~fifo_full;
                if (!inst.req || mem.addr_ok) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command fields follow the grant; they are don't-care whenever mem_req is low
    assign sel_cmd   = grant_data ? data_cmd : inst_cmd;
    assign mem.req   = mem_req_int;
    assign mem.wr    = sel_cmd.wr;
    assign mem.size  = sel_cmd.size;
    assign mem.addr  = sel_cmd.addr;
    assign mem.wstrb = sel_cmd.wstrb;
    assign mem.wdata = sel_cmd.wdata;

    assign accept       = mem_req_int & mem.addr_ok;
    assign inst.addr_ok = accept & grant_inst;
    assign data.addr_ok = accept & grant_data;

    // A response only counts when something is outstanding; it goes to the recorded owner
    assign resp_hit     = mem.data_ok & ~fifo_empty;
    assign inst.data_ok = resp_hit & (fifo_head == ARB_ID_INST);
    assign data.data_ok = resp_hit & (fifo_head == ARB_ID_DATA);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    arb_id_fifo #(
        .DEPTH (OUTST),
        .PTR_W (OUTST_W)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (grant_data ? ARB_ID_DATA : ARB_ID_INST),
        .pop     (mem.data_ok),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outst_cnt)
    );

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (mem.data_ok && fifo_empty) begin
            resp_err <= 1'b1;
        end
    end

endmodule
